// File: rtl/riscv_immenc_pkg.sv
// Shared constants, FSM state type and helpers for the immediate encoder.
package riscv_immenc_pkg;

  localparam logic [2:0] SRC_IMM_I = 3'd0;
  localparam logic [2:0] SRC_IMM_S = 3'd1;
  localparam logic [2:0] SRC_IMM_B = 3'd2;
  localparam logic [2:0] SRC_IMM_U = 3'd3;
  localparam logic [2:0] SRC_IMM_J = 3'd4;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    StIdle,
    StOut,
    StLui
  } state_e;

  // True when v is representable as a bits-wide two's-complement value.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] ext;
    ext = 32'($signed(v) >>> (bits - 1));
    return (ext == '0) || (ext == '1);
  endfunction

endpackage

// File: rtl/riscv_immenc_pack.sv
// Combinational packer: scatters an immediate into one instruction format of a template word.
module riscv_immenc_pack
  import riscv_immenc_pkg::*;
(
  input  logic [2:0]  src,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  always_comb begin
    instr = base;
    err   = 1'b0;
    case (src)
      SRC_IMM_I: begin
        instr[31:20] = imm[11:0];
        err          = !fits_signed(imm, 12);
      end
      SRC_IMM_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
        err          = !fits_signed(imm, 12);
      end
      SRC_IMM_B: begin
        instr[31]    = imm[12];
        instr[7]     = imm[11];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        err          = imm[0] | !fits_signed(imm, 13);
      end
      SRC_IMM_U: begin
        instr[31:12] = imm[31:12];
        err          = |imm[11:0];
      end
      SRC_IMM_J: begin
        instr[31]    = imm[20];
        instr[30:21] = imm[10:1];
        instr[20]    = imm[11];
        instr[19:12] = imm[19:12];
        err          = imm[0] | !fits_signed(imm, 21);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_immenc.sv
// Immediate encoder with LI expansion; valid/ready on both sides, one registered output word
// plus a hold register for the ADDI half of a two-word LI.
module riscv_immenc
  import riscv_immenc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_immenc_valid,
  output logic            o_immenc_ready,
  input  logic [2:0]      i_immenc_src,
  input  logic            i_immenc_li,
  input  logic [XLEN-1:0] i_immenc_base,
  input  logic [XLEN-1:0] i_immenc_imm,
  output logic            o_immenc_valid,
  input  logic            i_immenc_ready,
  output logic [XLEN-1:0] o_immenc_instr,
  output logic            o_immenc_err
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] hold_q, hold_d;

  logic [XLEN-1:0] pack_instr;
  logic            pack_err;

  riscv_immenc_pack u_pack (
    .src   (i_immenc_src),
    .base  (i_immenc_base),
    .imm   (i_immenc_imm),
    .instr (pack_instr),
    .err   (pack_err)
  );

  logic [4:0]      li_rd;
  logic            li_short;
  logic            li_two;
  logic [19:0]     li_upper;
  logic [XLEN-1:0] li_lui;
  logic [XLEN-1:0] li_addi_x0;
  logic [XLEN-1:0] li_addi_rd;
  logic [XLEN-1:0] first_instr;
  logic            first_err;
  logic            accept;

  always_comb begin
    li_rd      = i_immenc_base[11:7];
    li_short   = fits_signed(i_immenc_imm, 12);
    li_two     = !li_short && (|i_immenc_imm[11:0]);
    // Rounding by +0x800 only carries into bit 12 when imm[11] is set.
    li_upper   = i_immenc_imm[31:12] + {19'd0, i_immenc_imm[11]};
    li_lui     = {li_upper, li_rd, OPC_LUI};
    li_addi_x0 = {i_immenc_imm[11:0], 5'd0, 3'b000, li_rd, OPC_OP_IMM};
    li_addi_rd = {i_immenc_imm[11:0], li_rd, 3'b000, li_rd, OPC_OP_IMM};
    if (i_immenc_li) begin
      first_instr = li_short ? li_addi_x0 : li_lui;
      first_err   = 1'b0;
    end else begin
      first_instr = pack_instr;
      first_err   = pack_err;
    end
  end

  // Output comb
  always_comb begin
    o_immenc_valid = (state_q != StIdle);
    o_immenc_ready = (state_q == StIdle) || ((state_q == StOut) && i_immenc_ready);
    o_immenc_instr = instr_q;
    o_immenc_err   = err_q;
  end

  assign accept = i_immenc_valid && o_immenc_ready;

  // Next-state comb
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    err_d   = err_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: ;
      StOut: if (i_immenc_ready) state_d = StIdle;
      StLui: begin
        if (i_immenc_ready) begin
          instr_d = hold_q;
          err_d   = 1'b0;
          state_d = StOut;
        end
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      instr_d = first_instr;
      err_d   = first_err;
      hold_d  = li_addi_rd;
      state_d = (i_immenc_li && li_two) ? StLui : StOut;
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      instr_q <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_riscv_immenc.sv
// Bench for riscv_immenc: directed vectors with literal expectations plus a queue model.
module tb_riscv_immenc;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_src;
  logic        req_li;
  logic [31:0] req_base;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  always #5 clk = ~clk;

  riscv_immenc #(.XLEN(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_immenc_valid (req_valid),
    .o_immenc_ready (req_ready),
    .i_immenc_src   (req_src),
    .i_immenc_li    (req_li),
    .i_immenc_base  (req_base),
    .i_immenc_imm   (req_imm),
    .o_immenc_valid (out_valid),
    .i_immenc_ready (out_ready),
    .o_immenc_instr (out_instr),
    .o_immenc_err   (out_err)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [2:0]  src;
    logic [31:0] imm;
    logic        li;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } got_t;

  exp_t q[$];
  got_t log_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [31:0] v, input int bits);
    int lo, hi;
    lo = -(1 << (bits - 1));
    hi = (1 << (bits - 1)) - 1;
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

  // Expected words per request, from the format tables and the LI expansion rule.
  function automatic void model_push(input logic [2:0] src, input logic li,
                                     input logic [31:0] base, input logic [31:0] imm);
    exp_t        e;
    logic [31:0] rd, mask, f, lo12;
    e.src = src; e.imm = imm; e.li = li; e.err = 1'b0;
    rd   = {27'd0, base[11:7]};
    lo12 = imm & 32'hFFF;
    if (li) begin
      if (in_range(imm, 12)) begin
        e.instr = (lo12 << 20) | (rd << 7) | 32'h13;
        q.push_back(e);
      end else begin
        e.instr = (((imm + 32'h800) >> 12) << 12) | (rd << 7) | 32'h37;
        q.push_back(e);
        if (lo12 != 0) begin
          e.instr = (lo12 << 20) | (rd << 15) | (rd << 7) | 32'h13;
          q.push_back(e);
        end
      end
    end else begin
      case (src)
        3'd0: begin
          mask = 32'hFFF00000; f = lo12 << 20; e.err = !in_range(imm, 12);
        end
        3'd1: begin
          mask = 32'hFE000F80;
          f = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
          e.err = !in_range(imm, 12);
        end
        3'd2: begin
          mask = 32'hFE000F80;
          f = (((imm >> 12) & 32'h1) << 31) | (((imm >> 11) & 32'h1) << 7)
            | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8);
          e.err = imm[0] || !in_range(imm, 13);
        end
        3'd3: begin
          mask = 32'hFFFFF000; f = imm & 32'hFFFFF000; e.err = (lo12 != 0);
        end
        3'd4: begin
          mask = 32'hFFFFF000;
          f = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
          e.err = imm[0] || !in_range(imm, 21);
        end
        default: begin
          mask = 32'h0; f = 32'h0; e.err = 1'b1;
        end
      endcase
      e.instr = (base & ~mask) | f;
      q.push_back(e);
    end
  endfunction

  // Immediate extender, used to confirm the round trip on every error-free word.
  function automatic logic [31:0] immext(input logic [31:0] w, input logic [2:0] src);
    case (src)
      3'd0:    return {{20{w[31]}}, w[31:20]};
      3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {w[31:12], 12'd0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  // Compare process: handshake-level view of the DUT against the model queue.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      chk("o_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("o_ready", 32'(req_ready), 32'(q.size() == 0 || (q.size() == 1 && out_ready)));
      if (out_valid && q.size() != 0) begin
        chk("instr", out_instr, q[0].instr);
        chk("err", 32'(out_err), 32'(q[0].err));
      end
      if (out_valid && out_ready) begin
        log_q.push_back('{instr: out_instr, err: out_err});
        if (q.size() != 0) begin
          if (!q[0].li && !q[0].err && q[0].src < 3'd5)
            chk("roundtrip", immext(out_instr, q[0].src), q[0].imm);
          void'(q.pop_front());
        end
      end
      if (req_valid && req_ready) model_push(req_src, req_li, req_base, req_imm);
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Drive a request at posedge+1 and hold until accepted; returns at posedge+1 after accept.
  task automatic send(input logic [2:0] src, input logic li, input logic [31:0] base,
                      input logic [31:0] imm);
    int n;
    n = 0;
    req_valid = 1'b1; req_src = src; req_li = li; req_base = base; req_imm = imm;
    forever begin
      @(negedge clk);
      if (req_ready || n >= 50) break;
      n++;
    end
    chk("accept_bound", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_bound", 32'(out_valid), 32'd0);
  endtask

  task automatic chk_log(input int idx, input string name, input logic [31:0] instr,
                         input logic err);
    if (log_q.size() > idx) begin
      chk({name, "_instr"}, log_q[idx].instr, instr);
      chk({name, "_err"}, 32'(log_q[idx].err), 32'(err));
    end else begin
      chk({name, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, t, imm;
    time         t0;
    rst = 1'b1; req_valid = 1'b0; req_src = '0; req_li = 1'b0;
    req_base = '0; req_imm = '0; out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // I-type, latency
    log_q.delete();
    send(3'd0, 1'b0, 32'h00000013, 32'hFFFFFFFF);
    idle();
    chk("i_latency_valid", 32'(out_valid), 32'd1);
    drain();
    chk_log(0, "i_neg1", 32'hFFF00013, 1'b0);

    // B-type and its error cases
    log_q.delete();
    send(3'd2, 1'b0, 32'h00000063, 32'h00000FFE);
    send(3'd2, 1'b0, 32'h00000063, 32'h00000003);
    send(3'd2, 1'b0, 32'h00000063, 32'h00001000);
    idle(); drain();
    chk_log(0, "b_ffe", 32'h7E000FE3, 1'b0);
    if (log_q.size() > 1) chk("b_odd_err", 32'(log_q[1].err), 32'd1);
    if (log_q.size() > 2) chk("b_range_err", 32'(log_q[2].err), 32'd1);

    // LI two-word
    log_q.delete();
    send(3'd0, 1'b1, 32'h00000280, 32'h12345FFF);
    idle();
    chk("li2_lui_ready", 32'(req_ready), 32'd0);
    chk("li2_lui_instr", out_instr, 32'h123462B7);
    drain();
    chk_log(0, "li2_lui", 32'h123462B7, 1'b0);
    chk_log(1, "li2_addi", 32'hFFF28293, 1'b0);
    chk("li2_count", 32'(log_q.size()), 32'd2);

    // LI one-word forms
    log_q.delete();
    send(3'd0, 1'b1, 32'h00000280, 32'h00012000);
    idle(); drain();
    send(3'd0, 1'b1, 32'h00000280, 32'hFFFFFFFB);
    idle(); drain();
    chk_log(0, "li1_lui", 32'h000122B7, 1'b0);
    chk_log(1, "li1_addi", 32'hFFB00293, 1'b0);
    chk("li1_count", 32'(log_q.size()), 32'd2);

    // Backpressure in the LUI beat
    log_q.delete();
    out_ready = 1'b0;
    send(3'd0, 1'b1, 32'h00000280, 32'h12345FFF);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_instr", out_instr, 32'h123462B7);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    drain();
    chk_log(0, "bp_lui", 32'h123462B7, 1'b0);
    chk_log(1, "bp_addi", 32'hFFF28293, 1'b0);

    // Back-to-back I requests at full rate
    log_q.delete();
    t0 = $time;
    for (int k = 1; k <= 4; k++) send(3'd0, 1'b0, 32'h00000013, 32'(k));
    chk("b2b_cycles", 32'(($time - t0) / 10), 32'd4);
    idle(); drain();
    for (int k = 1; k <= 4; k++) chk_log(k - 1, "b2b", (32'(k) << 20) | 32'h13, 1'b0);

    // Reset while the ADDI is pending
    log_q.delete();
    out_ready = 1'b0;
    send(3'd0, 1'b1, 32'h00000280, 32'h12345FFF);
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_no_addi", 32'(log_q.size()), 32'd0);
    chk("rst_mid_idle", 32'(out_valid), 32'd0);

    // Random formats and immediates under random downstream stalls
    rand_rdy = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      r = $urandom;
      case ($urandom_range(0, 4))
        0: imm = r;
        1: begin t = r << 20; imm = $signed(t) >>> 20; end
        2: begin t = r << 19; imm = ($signed(t) >>> 19) & 32'hFFFFFFFE; end
        3: begin t = r << 11; imm = ($signed(t) >>> 11) & 32'hFFFFFFFE; end
        default: imm = r & 32'hFFFFF000;
      endcase
      send(3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), $urandom, imm);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end
    end
    idle();
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
